// File: rtl/cpuif_timeout_bridge.sv
// cpuif_timeout_bridge: one-outstanding registered CPUIF stage with a bounded-latency timeout.
// An access that the register block never answers completes with an error response instead of hanging the bus.
module cpuif_timeout_bridge #(
    parameter int unsigned             ADDR_WIDTH     = 18,
    parameter int unsigned             DATA_WIDTH     = 32,
    parameter int unsigned             TIMEOUT_CYCLES = 256,
    parameter logic [DATA_WIDTH-1:0]   ERR_RDATA      = 32'hDEADBEEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  s_cpuif_req,
    input  logic                  s_cpuif_req_is_wr,
    input  logic [ADDR_WIDTH-1:0] s_cpuif_addr,
    input  logic [DATA_WIDTH-1:0] s_cpuif_wr_data,
    input  logic [DATA_WIDTH-1:0] s_cpuif_wr_biten,
    output logic                  s_cpuif_req_stall_wr,
    output logic                  s_cpuif_req_stall_rd,
    output logic                  s_cpuif_rd_ack,
    output logic                  s_cpuif_rd_err,
    output logic [DATA_WIDTH-1:0] s_cpuif_rd_data,
    output logic                  s_cpuif_wr_ack,
    output logic                  s_cpuif_wr_err,
    output logic                  m_cpuif_req,
    output logic                  m_cpuif_req_is_wr,
    output logic [ADDR_WIDTH-1:0] m_cpuif_addr,
    output logic [DATA_WIDTH-1:0] m_cpuif_wr_data,
    output logic [DATA_WIDTH-1:0] m_cpuif_wr_biten,
    input  logic                  m_cpuif_req_stall_wr,
    input  logic                  m_cpuif_req_stall_rd,
    input  logic                  m_cpuif_rd_ack,
    input  logic                  m_cpuif_rd_err,
    input  logic [DATA_WIDTH-1:0] m_cpuif_rd_data,
    input  logic                  m_cpuif_wr_ack,
    input  logic                  m_cpuif_wr_err,
    output logic                  timeout_o
);
    localparam int unsigned CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic                  is_wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] biten_q;
    logic                  m_req_q;
    logic                  stall_q;
    logic                  rd_ack_q;
    logic                  rd_err_q;
    logic                  wr_ack_q;
    logic                  wr_err_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  timeout_q;

    logic sel_stall;
    logic sel_ack;
    logic sel_err;
    logic hit;
    logic expire;

    assign sel_stall = is_wr_q ? m_cpuif_req_stall_wr : m_cpuif_req_stall_rd;
    assign sel_ack   = is_wr_q ? m_cpuif_wr_ack : m_cpuif_rd_ack;
    assign sel_err   = is_wr_q ? m_cpuif_wr_err : m_cpuif_rd_err;
    // A stalled request has not been taken yet, so an ack seen alongside the stall cannot belong to it.
    assign hit       = sel_ack && (state_q == WAIT || !sel_stall);
    assign expire    = (TIMEOUT_CYCLES != 0) && (cnt_q == LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_wr_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            biten_q   <= '0;
            m_req_q   <= 1'b0;
            stall_q   <= 1'b0;
            rd_ack_q  <= 1'b0;
            rd_err_q  <= 1'b0;
            wr_ack_q  <= 1'b0;
            wr_err_q  <= 1'b0;
            rdata_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            rd_ack_q  <= 1'b0;
            rd_err_q  <= 1'b0;
            wr_ack_q  <= 1'b0;
            wr_err_q  <= 1'b0;
            rdata_q   <= '0;
            timeout_q <= 1'b0;
            case (state_q)
                IDLE, RESP: begin
                    if (s_cpuif_req) begin
                        state_q <= ISSUE;
                        cnt_q   <= '0;
                        is_wr_q <= s_cpuif_req_is_wr;
                        addr_q  <= s_cpuif_addr;
                        wdata_q <= s_cpuif_wr_data;
                        biten_q <= s_cpuif_wr_biten;
                        m_req_q <= 1'b1;
                        stall_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (hit || expire) begin
                        state_q   <= RESP;
                        m_req_q   <= 1'b0;
                        stall_q   <= 1'b0;
                        rd_ack_q  <= !is_wr_q;
                        wr_ack_q  <= is_wr_q;
                        rd_err_q  <= !is_wr_q && (hit ? sel_err : 1'b1);
                        wr_err_q  <= is_wr_q && (hit ? sel_err : 1'b1);
                        rdata_q   <= is_wr_q ? '0 : (hit ? m_cpuif_rd_data : ERR_RDATA);
                        timeout_q <= !hit;
                    end else if (state_q == ISSUE && !sel_stall) begin
                        state_q <= WAIT;
                        m_req_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign s_cpuif_req_stall_wr = stall_q;
    assign s_cpuif_req_stall_rd = stall_q;
    assign s_cpuif_rd_ack       = rd_ack_q;
    assign s_cpuif_rd_err       = rd_err_q;
    assign s_cpuif_rd_data      = rdata_q;
    assign s_cpuif_wr_ack       = wr_ack_q;
    assign s_cpuif_wr_err       = wr_err_q;
    assign m_cpuif_req          = m_req_q;
    assign m_cpuif_req_is_wr    = is_wr_q;
    assign m_cpuif_addr         = addr_q;
    assign m_cpuif_wr_data      = wdata_q;
    assign m_cpuif_wr_biten     = biten_q;
    assign timeout_o            = timeout_q;
endmodule
